// File: rtl/alu_op_issue.sv
// ID/EX boundary register for ALU-type ops: decodes opcode/funct3/funct7[5] into
// ALU unit controls and registers them with both operands; supports stall, flush, issue count.
module alu_op_issue #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7b5_i,
  input  logic [WIDTH-1:0]     rs1_data_i,
  input  logic [WIDTH-1:0]     rs2_data_i,
  input  logic [WIDTH-1:0]     imm_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [WIDTH-1:0]     A_o,
  output logic [WIDTH-1:0]     B_o,
  output logic [1:0]           unit_sel_o,
  output logic [1:0]           logic_op_o,
  output logic                 sub_o,
  output logic [1:0]           shift_op_o,
  output logic                 cmp_unsigned_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] issue_cnt_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_SHIFT = 2'b10;
  localparam logic [1:0] UNIT_CMP   = 2'b11;

  localparam logic [1:0] LOP_AND  = 2'b00;
  localparam logic [1:0] LOP_XOR  = 2'b01;
  localparam logic [1:0] LOP_OR   = 2'b10;
  localparam logic [1:0] LOP_NONE = 2'b11;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  typedef struct packed {
    logic [1:0] unit_sel;
    logic [1:0] logic_op;
    logic       sub;
    logic [1:0] shift_op;
    logic       cmp_unsigned;
    logic       illegal;
    logic       use_imm;
  } ctrl_t;

  ctrl_t dec;
  logic  is_reg;
  logic  is_imm;
  logic  is_mem;
  logic  alu_legal;

  // Handshake: an op in the output register is issued on a rising edge where
  // valid_o=1 and stall_i=0 (and no flush); decode may present a new op whenever
  // ready_o=1, and ready_o is simply ~stall_i so it never depends on valid_i.
  assign ready_o = ~stall_i;

  // Default is the "illegal nop": logic unit with no operation, so the ALU yields 0.
  always_comb begin
    dec       = '{unit_sel: UNIT_LOGIC, logic_op: LOP_NONE, sub: 1'b0, shift_op: 2'b00,
                  cmp_unsigned: 1'b0, illegal: 1'b1, use_imm: 1'b1};
    is_reg    = (opcode_i == OPC_OP);
    is_imm    = (opcode_i == OPC_IMM);
    is_mem    = (opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE);
    alu_legal = (is_reg && (!funct7b5_i || funct3_i == 3'b000 || funct3_i == 3'b101)) ||
                (is_imm && !(funct3_i == 3'b001 && funct7b5_i));

    if (is_mem) begin
      dec.unit_sel = UNIT_ARITH;
      dec.illegal  = 1'b0;
    end else if (alu_legal) begin
      dec.illegal = 1'b0;
      dec.use_imm = is_imm;
      case (funct3_i)
        3'b000: begin
          dec.unit_sel = UNIT_ARITH;
          dec.sub      = is_reg & funct7b5_i;
        end
        3'b001: begin
          dec.unit_sel = UNIT_SHIFT;
          dec.shift_op = SH_SLL;
        end
        3'b010: dec.unit_sel = UNIT_CMP;
        3'b011: begin
          dec.unit_sel     = UNIT_CMP;
          dec.cmp_unsigned = 1'b1;
        end
        3'b100: dec.logic_op = LOP_XOR;
        3'b101: begin
          dec.unit_sel = UNIT_SHIFT;
          dec.shift_op = funct7b5_i ? SH_SRA : SH_SRL;
        end
        3'b110: dec.logic_op = LOP_OR;
        default: dec.logic_op = LOP_AND;
      endcase
    end else if (is_reg) begin
      dec.use_imm = 1'b0;
    end
  end

  // Flush wins over stall; fields other than valid/illegal are left as they were.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o        <= 1'b0;
      A_o            <= '0;
      B_o            <= '0;
      unit_sel_o     <= 2'b00;
      logic_op_o     <= LOP_NONE;
      sub_o          <= 1'b0;
      shift_op_o     <= 2'b00;
      cmp_unsigned_o <= 1'b0;
      illegal_o      <= 1'b0;
    end else if (flush_i) begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o        <= valid_i;
      A_o            <= rs1_data_i;
      B_o            <= dec.use_imm ? imm_i : rs2_data_i;
      unit_sel_o     <= dec.unit_sel;
      logic_op_o     <= dec.logic_op;
      sub_o          <= dec.sub;
      shift_op_o     <= dec.shift_op;
      cmp_unsigned_o <= dec.cmp_unsigned;
      illegal_o      <= valid_i & dec.illegal;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cnt_o <= '0;
    end else if (valid_o && !stall_i && !flush_i) begin
      issue_cnt_o <= issue_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed ops with hand-computed controls go into an expected
// queue; a negedge monitor pops and compares whenever the DUT issues an op.
module tb_alu_op_issue;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int EW = 74;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BRNCH = 7'b1100011;

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [W-1:0]  rs1_data;
  logic [W-1:0]  rs2_data;
  logic [W-1:0]  imm;
  logic          stall;
  logic          flush;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  a_o;
  logic [W-1:0]  b_o;
  logic [1:0]    unit_sel_o;
  logic [1:0]    logic_op_o;
  logic          sub_o;
  logic [1:0]    shift_op_o;
  logic          cmp_unsigned_o;
  logic          illegal_o;
  logic [CW-1:0] issue_cnt_o;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] out_vec;
  int            checks;
  int            errors;

  alu_op_issue #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .opcode_i(opcode), .funct3_i(funct3),
    .funct7b5_i(funct7b5), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .stall_i(stall), .flush_i(flush), .ready_o(ready_o), .valid_o(valid_o), .A_o(a_o),
    .B_o(b_o), .unit_sel_o(unit_sel_o), .logic_op_o(logic_op_o), .sub_o(sub_o),
    .shift_op_o(shift_op_o), .cmp_unsigned_o(cmp_unsigned_o), .illegal_o(illegal_o),
    .issue_cnt_o(issue_cnt_o)
  );

  assign out_vec = {valid_o, a_o, b_o, unit_sel_o, logic_op_o, sub_o, shift_op_o,
                    cmp_unsigned_o, illegal_o};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && valid_o && !stall && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %h, required no issue", out_vec);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (out_vec !== e) begin
          errors++;
          $display("FAIL issue: got %h, required %h", out_vec, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input logic [EW-1:0] e);
    checks++;
    if (out_vec !== e) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, out_vec, e);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, e);
    end
  endtask

  // driver: one valid op, unstalled, with its hand-computed controls queued
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                       input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] im,
                       input logic [1:0] eu, input logic [1:0] el, input logic es,
                       input logic [1:0] esh, input logic ec, input logic ei,
                       input logic eb_imm);
    valid_i  = 1'b1;
    opcode   = op;
    funct3   = f3;
    funct7b5 = b5;
    rs1_data = r1;
    rs2_data = r2;
    imm      = im;
    stall    = 1'b0;
    flush    = 1'b0;
    exp_q.push_back({1'b1, r1, (eb_imm ? im : r2), eu, el, es, esh, ec, ei});
    tick();
  endtask

  // driver: background cycle with random data; never call with v=1, st=0, fl=0
  task automatic bg(input logic v, input logic st, input logic fl);
    valid_i  = v;
    opcode   = 7'($urandom_range(0, 127));
    funct3   = 3'($urandom_range(0, 7));
    funct7b5 = 1'($urandom_range(0, 1));
    rs1_data = $urandom;
    rs2_data = $urandom;
    imm      = $urandom;
    stall    = st;
    flush    = fl;
    tick();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_vec("reset_async_outputs", {1'b0, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0});
    check_val("reset_async_cnt", 32'(issue_cnt_o), 32'h0);
    exp_q.delete();
    valid_i = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [EW-1:0] xor_vec;
    int            budget;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    valid_i  = 1'b0;
    opcode   = '0;
    funct3   = '0;
    funct7b5 = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    imm      = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    #1;
    check_vec("reset_outputs", {1'b0, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0});
    check_val("reset_cnt", 32'(issue_cnt_o), 32'h0);
    check_val("ready_unstalled", 32'(ready_o), 32'h1);
    tick();
    rst = 1'b0;

    // decode vectors (args: op f3 b5 rs1 rs2 imm | unit lop sub shift cmpu illegal B=imm)
    issue(OP,    3'b111, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000123, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(OPI,   3'b100, 1'b1, 32'h12345678, 32'hAAAAAAAA, 32'hFFFFFFFF, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    issue(OP,    3'b110, 1'b0, 32'h0000FFFF, 32'h5A5A5A5A, 32'h00000777, 2'b01, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(OP,    3'b000, 1'b1, 32'h00000010, 32'h00000003, 32'h00000800, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(OPI,   3'b000, 1'b1, 32'h00000010, 32'h00000003, 32'hFFFFF800, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    issue(OP,    3'b100, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000001, 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    issue(OP,    3'b101, 1'b1, 32'h80000000, 32'h00000004, 32'h00000000, 2'b10, 2'b11, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    issue(OPI,   3'b101, 1'b0, 32'h80000000, 32'h00000000, 32'h00000004, 2'b10, 2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    issue(OPI,   3'b101, 1'b1, 32'h80000000, 32'h00000009, 32'h00000404, 2'b10, 2'b11, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    issue(OP,    3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000005, 2'b11, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    issue(OPI,   3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000005, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    issue(LOAD,  3'b010, 1'b1, 32'h00001000, 32'h77777777, 32'h00000010, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    issue(STORE, 3'b010, 1'b0, 32'h00002000, 32'h66666666, 32'hFFFFFFFC, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    issue(BRNCH, 3'b000, 1'b0, 32'h00000042, 32'h00000042, 32'h00000100, 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    issue(OPI,   3'b001, 1'b1, 32'h00000001, 32'h00000002, 32'h00000403, 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    issue(OP,    3'b001, 1'b0, 32'h00000001, 32'h0000001F, 32'h00000000, 2'b10, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(OP,    3'b010, 1'b1, 32'h00000003, 32'h00000004, 32'h00000000, 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    bg(1'b0, 1'b0, 1'b0);
    check_val("invalid_capture_valid", 32'(valid_o), 32'h0);
    check_val("invalid_capture_illegal", 32'(illegal_o), 32'h0);

    // stall holds the XOR op while inputs change, then it issues once
    xor_vec = {1'b1, 32'h11111111, 32'h22222222, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
    issue(OP, 3'b100, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bg(1'b1, 1'b1, 1'b0);
      check_vec("stall_hold", xor_vec);
    end
    check_val("ready_stalled", 32'(ready_o), 32'h0);
    bg(1'b0, 1'b0, 1'b0);

    // flush during stall kills the held op
    issue(OP, 3'b111, 1'b0, 32'h0000AAAA, 32'h00005555, 32'h0, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    bg(1'b1, 1'b1, 1'b0);
    void'(exp_q.pop_back());
    bg(1'b1, 1'b1, 1'b1);
    check_val("flush_in_stall_valid", 32'(valid_o), 32'h0);
    check_val("flush_in_stall_illegal", 32'(illegal_o), 32'h0);

    // flush at capture of an illegal op
    valid_i = 1'b1; opcode = BRNCH; funct3 = 3'b000; funct7b5 = 1'b0; stall = 1'b0; flush = 1'b1;
    tick();
    check_val("flush_capture_valid", 32'(valid_o), 32'h0);
    check_val("flush_capture_illegal", 32'(illegal_o), 32'h0);

    // async reset mid-stream discards a held op
    issue(OP, 3'b110, 1'b0, 32'h0000000F, 32'h000000F0, 32'h0, 2'b01, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(OP, 3'b000, 1'b0, 32'h00000005, 32'h00000006, 32'h0, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    bg(1'b1, 1'b1, 1'b0);
    async_reset();
    check_val("post_reset_valid", 32'(valid_o), 32'h0);

    // counter: 17 issues with 2 stalled cycles wraps the 4-bit count to 1
    for (int i = 0; i < 17; i++) begin
      logic [W-1:0] r1, r2;
      r1 = $urandom;
      r2 = $urandom;
      issue(OP, 3'b000, 1'b0, r1, r2, 32'h0, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      if (i == 7) begin
        bg(1'b1, 1'b1, 1'b0);
        bg(1'b1, 1'b1, 1'b0);
        check_val("cnt_during_stall", 32'(issue_cnt_o), 32'h7);
      end
    end
    bg(1'b0, 1'b0, 1'b0);
    bg(1'b0, 1'b0, 1'b0);
    check_val("cnt_wrap", 32'(issue_cnt_o), 32'h1);

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      bg(1'b0, 1'b0, 1'b0);
      budget++;
    end
    check_val("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
